// File: rtl/code_reconverter_if.sv
// Request/result bundle for code_reconverter.
// master drives the coded operand, slave returns the decode.
interface code_reconverter_if;
  logic [7:0] a_in;
  logic [3:0] op_in;
  logic       en_in;
  logic [7:0] y_out;
  logic       done_out;
  logic       busy_out;
  logic       err_out;

  modport master (
    output a_in, op_in, en_in,
    input  y_out, done_out, busy_out, err_out
  );

  modport slave (
    input  a_in, op_in, en_in,
    output y_out, done_out, busy_out, err_out
  );
endinterface

// File: rtl/code_reconverter.sv
// Iterative Gray/XS-3/XS-5/BCD to binary decoder, one bit per clock.
// Define CODE_RECONV_CHECK_EN to enable operand range checking.
module code_reconverter #(
  parameter int GRAY_W = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  code_reconverter_if.slave io
);

  typedef enum logic {
    S_IDLE,
    S_CALC
  } state_t;

  typedef enum logic [2:0] {
    K_INV,
    K_GRAY,
    K_XS3,
    K_XS5,
    K_BCD
  } kind_t;

  localparam logic [7:0] GMASK =
    8'(8'hFF << (8 - GRAY_W));
  localparam logic [2:0] GCNT = 3'(GRAY_W - 1);

  state_t      state_q;
  kind_t       kind_q;
  logic [2:0]  cnt_q;
  logic [15:0] sh_q;
  logic        pb_q;
  logic        errp_q;
  logic [7:0]  y_q;
  logic        done_q;
  logic        busy_q;
  logic        err_q;

  kind_t       kind_d;
  kind_t       kind_go;
  logic        op_ok;
  logic        rerr;
  logic [2:0]  cnt_go;
  logic [15:0] sh_go;

  logic [15:0] sh_d;
  logic        pb_d;
  logic [7:0]  res;
  logic        nb;
  logic [15:0] t;
  logic [3:0]  hi;
  logic [3:0]  lo;

  assign op_ok = (io.op_in != 4'd0) &&
    ((io.op_in & (io.op_in - 4'd1)) == 4'd0);

  always_comb begin
    kind_d = K_INV;
    if (op_ok) begin
      unique case (1'b1)
        io.op_in[0]: kind_d = K_GRAY;
        io.op_in[1]: kind_d = K_XS3;
        io.op_in[2]: kind_d = K_XS5;
        io.op_in[3]: kind_d = K_BCD;
        default:     kind_d = K_INV;
      endcase
    end
  end

`ifdef CODE_RECONV_CHECK_EN
  always_comb begin
    rerr = 1'b0;
    unique case (kind_d)
      K_INV: rerr = 1'b1;
      K_XS3: rerr = (io.a_in < 8'd3) ||
                    (io.a_in > 8'd18);
      K_XS5: rerr = (io.a_in < 8'd5) ||
                    (io.a_in > 8'd20);
      K_BCD: rerr = (io.a_in[7:4] > 4'd9) ||
                    (io.a_in[3:0] > 4'd9);
      default: rerr = 1'b0;
    endcase
  end
`else
  assign rerr = 1'b0;
`endif

  // A range error collapses to the invalid path: one cycle, y=0.
  always_comb begin
    kind_go = rerr ? K_INV : kind_d;
    cnt_go  = 3'd0;
    sh_go   = {io.a_in, 8'h00};
    unique case (kind_go)
      K_GRAY: begin
        cnt_go = GCNT;
        sh_go  = {io.a_in & GMASK, 8'h00};
      end
      K_BCD:   cnt_go = 3'd7;
      default: cnt_go = 3'd0;
    endcase
  end

  // Gray: code bits leave sh_q[15], binary bits enter sh_q[0].
  // BCD: shift right, then pull back any nibble that reached 8.
  assign nb = pb_q ^ sh_q[15];
  assign t  = sh_q >> 1;
  assign hi = (t[15:12] >= 4'd8) ?
              t[15:12] - 4'd3 : t[15:12];
  assign lo = (t[11:8] >= 4'd8) ?
              t[11:8] - 4'd3 : t[11:8];

  always_comb begin
    sh_d = sh_q;
    pb_d = pb_q;
    res  = 8'h00;
    unique case (kind_q)
      K_GRAY: begin
        sh_d = {sh_q[14:8], 1'b0,
                sh_q[6:0], nb};
        pb_d = nb;
        res  = sh_d[7:0];
      end
      K_XS3: res = sh_q[15:8] - 8'd3;
      K_XS5: res = sh_q[15:8] - 8'd5;
      K_BCD: begin
        sh_d = {hi, lo, t[7:0]};
        res  = sh_d[7:0];
      end
      default: res = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      kind_q  <= K_INV;
      cnt_q   <= 3'd0;
      sh_q    <= 16'h0000;
      pb_q    <= 1'b0;
      errp_q  <= 1'b0;
      y_q     <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!io.en_in) begin
            state_q <= S_CALC;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            kind_q  <= kind_go;
            cnt_q   <= cnt_go;
            sh_q    <= sh_go;
            pb_q    <= 1'b0;
            errp_q  <= rerr;
          end
        end
        S_CALC: begin
          sh_q <= sh_d;
          pb_q <= pb_d;
          if (cnt_q == 3'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            y_q     <= res;
            err_q   <= errp_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.y_out    = y_q;
  assign io.done_out = done_q;
  assign io.busy_out = busy_q;
  assign io.err_out  = err_q;

endmodule

// File: tb/tb_code_reconverter.sv
// Randomised bench for code_reconverter against an arithmetic model.
// Honours CODE_RECONV_CHECK_EN the same way the design does.
module tb_code_reconverter;

  localparam int GW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  code_reconverter_if ifc ();

  code_reconverter #(.GRAY_W(GW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .io       (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [7:0] a,
    input  logic [3:0] op,
    output logic [7:0] y,
    output logic       e,
    output int         n,
    output bit         ychk);
    bit oh;
    bit rng;
    logic [7:0] g;
    logic [7:0] b;
    oh = (op == 4'd1) || (op == 4'd2) ||
         (op == 4'd4) || (op == 4'd8);
    rng = !oh ||
      (op == 4'd2 && (a < 3 || a > 18)) ||
      (op == 4'd4 && (a < 5 || a > 20)) ||
      (op == 4'd8 &&
       (a[7:4] > 9 || a[3:0] > 9));
    y = 8'h00;
    e = 1'b0;
    n = 1;
    ychk = 1'b1;
`ifdef CODE_RECONV_CHECK_EN
    if (rng) begin
      e = 1'b1;
      return;
    end
`else
    if (rng && !oh) return;
`endif
    case (op)
      4'd1: begin
        g = a >> (8 - GW);
        b = 8'h00;
        for (int i = 0; i < 8; i++)
          b = b ^ (g >> i);
        y = b;
        n = GW;
      end
      4'd2: y = a - 8'd3;
      4'd4: y = a - 8'd5;
      default: begin
        n = 8;
        y = 8'(a[7:4] * 10 + a[3:0]);
        if (a[7:4] > 9 || a[3:0] > 9)
          ychk = 1'b0;
      end
    endcase
  endfunction

  // Starts at a negedge with the block idle or in its done cycle;
  // returns at the negedge showing done (the next op may chain here).
  task automatic do_op(input logic [7:0] a,
                       input logic [3:0] op,
                       input bit chaos);
    logic [7:0] ey;
    logic       ee;
    int         en;
    bit         yc;
    int         lat;
    int         nbusy;
    model(a, op, ey, ee, en, yc);
    ifc.a_in  = a;
    ifc.op_in = op;
    ifc.en_in = 1'b0;
    @(negedge clk);
    ifc.en_in = 1'b1;
    check("done_clr", 32'(ifc.done_out), 32'd0);
    check("err_clr", 32'(ifc.err_out), 32'd0);
    lat = 0;
    nbusy = 0;
    while (!ifc.done_out && lat < 40) begin
      if (ifc.busy_out) nbusy++;
      if (chaos) begin
        ifc.en_in = 1'($urandom);
        ifc.a_in  = 8'($urandom);
        ifc.op_in = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    ifc.en_in = 1'b1;
    check("latency", 32'(lat), 32'(en));
    check("busy_cyc", 32'(nbusy), 32'(en));
    check("busy_done", 32'(ifc.busy_out), 32'd0);
    if (yc) check("y", 32'(ifc.y_out), 32'(ey));
    check("err", 32'(ifc.err_out), 32'(ee));
  endtask

  initial begin
    logic [3:0] rop;
    logic [7:0] ra;
    bool_t_dummy: begin end
    ifc.a_in  = 8'h00;
    ifc.op_in = 4'h0;
    ifc.en_in = 1'b1;
    #12;
    check("rst_y", 32'(ifc.y_out), 32'd0);
    check("rst_done", 32'(ifc.done_out), 32'd0);
    check("rst_busy", 32'(ifc.busy_out), 32'd0);
    check("rst_err", 32'(ifc.err_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'hB0, 4'b0001, 1'b0);
    check("gray_y", 32'(ifc.y_out), 32'h0D);
    do_op(8'h0C, 4'b0010, 1'b0);
    do_op(8'h14, 4'b0100, 1'b0);
    check("xs5_y", 32'(ifc.y_out), 32'h0F);
    do_op(8'h99, 4'b1000, 1'b1);
    check("bcd99_y", 32'(ifc.y_out), 32'h63);
    do_op(8'h42, 4'b1000, 1'b1);
    check("bcd42_y", 32'(ifc.y_out), 32'h2A);
    do_op(8'h3A, 4'b1000, 1'b0);
    do_op(8'h55, 4'b0011, 1'b0);
    do_op(8'h02, 4'b0010, 1'b0);
    do_op(8'hFF, 4'b0001, 1'b0);

    // Abort a BCD decode in its third cycle.
    ifc.a_in  = 8'h77;
    ifc.op_in = 4'b1000;
    ifc.en_in = 1'b0;
    @(negedge clk);
    ifc.en_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_y", 32'(ifc.y_out), 32'd0);
    check("abort_busy", 32'(ifc.busy_out), 32'd0);
    check("abort_done", 32'(ifc.done_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (ifc.done_out) seen++;
      end
      check("abort_nodone", 32'(seen), 32'd0);
    end
    do_op(8'h77, 4'b1000, 1'b0);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: rop = 4'b0001;
        1: rop = 4'b0010;
        2: rop = 4'b0100;
        3, 4: rop = 4'b1000;
        default: rop = 4'($urandom);
      endcase
      ra = 8'($urandom);
      if (rop == 4'b1000 && $urandom_range(0, 3) != 0)
        ra = {4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9))};
      if ((rop == 4'b0010 || rop == 4'b0100) &&
          $urandom_range(0, 1) == 1)
        ra = 8'($urandom_range(0, 24));
      do_op(ra, rop, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("idle_done", 32'(ifc.done_out), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_reconverter.md
Name: code_reconverter

Overview:
Sequential inverse of the combinational code converter. It decodes Gray, excess-3, excess-5 and packed 2-digit BCD words back to plain binary. An operation is requested on an active-low enable. The multi-bit decodes run iteratively, one bit per clock, and finish with a single-cycle done pulse. The block sits on the ALU result path, downstream of the converter, for round-trip checking and for decoding external coded data.

Parameters:
GRAY_W, 4, Gray operand width (1..8). Operand is taken from a_in[7:8-GRAY_W]. Gray decode takes GRAY_W cycles.

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
a_in  input  8  coded operand
op_in  input  4  one-hot op: 0001 Gray->bin, 0010 XS-3->bin, 0100 XS-5->bin, 1000 BCD->bin
en_in  input  1  active-low request; sampled only while idle
y_out  output  8  decoded binary result, zero-extended
done_out  output  1  one-cycle pulse; y_out/err_out valid
busy_out  output  1  high while a decode is in progress
err_out  output  1  invalid operand/op flag, valid with done_out

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE; y_out=0, done_out=0, busy_out=0, err_out=0; internal shift registers cleared. Reset mid-operation aborts immediately, with no done pulse.
- FSM states:
  - IDLE: en_in=0 at a rising edge accepts the request and latches a_in and op_in. Next state is CALC with cycle counter=N-1. The edge that accepts the request is E0.
  - CALC: one iteration per cycle. At edge E_N, y_out and err_out update, done_out=1 for one cycle, and the FSM returns to IDLE.
- busy_out is high from E0 to E_N. It is low in the done cycle, so a new request can be accepted on the same edge that clears done_out (back-to-back operation).
- en_in, a_in and op_in are ignored while busy. a_in and op_in changes after E0 have no effect.
- y_out holds its value until the next E_N. err_out clears on each new acceptance.
- Latency N per op:
  - XS-3: N=1, y = a - 3, valid a 3..18.
  - XS-5: N=1, y = a - 5, valid a 5..20.
  - Gray: N=GRAY_W. Decode MSB first: b[msb]=g[msb], then b[i]=b[i+1]^g[i], one bit per cycle. Result in y_out[GRAY_W-1:0]; upper bits 0.
  - BCD: N=8, reverse double-dabble on a 16-bit register {bcd[7:0], bin[7:0]}. Each cycle: shift right 1, then subtract 3 from each BCD nibble that is >=8. After 8 cycles, y_out = bin. Valid range 00..99.
- Invalid op_in (zero, not one-hot, or undefined): N=1, y_out=0. err_out is set only as described under Optional Feature.
- Arithmetic is 8-bit, unsigned, wrap modulo 256 when unchecked.
- Simultaneous done and new request in IDLE-return cycle: the new request is accepted, and done_out still pulses for the finished op.

Optional Feature:
Macro CODE_RECONV_CHECK_EN.
- Defined: operand range is checked at acceptance. Out of range means:
  - XS-3 outside 3..18
  - XS-5 outside 5..20
  - BCD nibble >9
  - Invalid op_in
  On a range error: N=1, y_out=0, err_out=1 with done_out.
- Not defined: no checks; err_out tied 0; ops run their full N with modulo arithmetic. Invalid op still gives N=1, y_out=0.

Test Plan:
1. Gray: op=0001, a_in=8'hB0 (gray 1011), en_in low 1 cycle -> done at E4, y_out=8'h0D, err=0, busy high 4 cycles.
2. XS-3/XS-5: op=0010, a_in=8'h0C -> y_out=8'h09 at E1. Then op=0100, a_in=8'h14 -> y_out=8'h0F, back-to-back with no idle gap.
3. BCD: a_in=8'h99 -> y_out=8'h63 at E8. Then a_in=8'h42 -> 8'h2A. Toggling en_in and a_in while busy has no effect on either.
4. Check (macro on): BCD a_in=8'h3A -> done at E1, y_out=0, err_out=1. Macro off: same stimulus -> done at E8, err_out=0.
5. Invalid op: op_in=4'b0011 -> done at E1, y_out=0; err_out=1 only with macro.
6. Reset: drop rst_n_in at BCD cycle 3 -> y_out, busy_out, done_out all 0 immediately. No done pulse afterwards. Next request completes normally.
